// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants shared by the sync generator and the
// pixel-colour / snake-position blocks that need the screen bounds.
package vga_timing_pkg;

  localparam int COORD_W  = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test [lo, lo+len).
  function automatic logic in_win(input coord_t x, input coord_t lo, input coord_t len);
    return (x >= lo) && (x < coord_t'(lo + len));
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel clock-enable divider: one registered pix_tick every CLK_DIV system clocks.
module pix_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic adv_o,
  output logic pix_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pix_tick_q;

  // adv_o marks the edge on which the raster counters step; pix_tick_o
  // is the same event delayed one clock so it lines up with the new counts.
  assign adv_o = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (adv_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pix_tick_q <= adv_o;
    end
  end

  assign pix_tick_o = pix_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: hcount/vcount, visibility flags, syncs and per-frame strobes,
// all registered from next-state counts so every output is skew-free.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic               h_visable,
  output logic               v_visable,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_tick,
  output logic               frame_tick,
  output logic               vblank_tick
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LEN = coord_t'(H_SYNC);
  localparam coord_t VS_LO  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LEN = coord_t'(V_SYNC);

  logic   adv;
  coord_t h_q, h_d, v_q, v_d;
  logic   hvis_q, vvis_q, hsync_q, vsync_q, frame_q, vblank_q;

  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
    .clk        (clk),
    .rst        (rst),
    .adv_o      (adv),
    .pix_tick_o (pix_tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q      <= '0;
      v_q      <= '0;
      hvis_q   <= 1'b1;
      vvis_q   <= 1'b1;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hvis_q   <= (h_d < H_ACT);
      vvis_q   <= (v_d < V_ACT);
      hsync_q  <= in_win(h_d, HS_LO, HS_LEN) ? SYNC_POL : ~SYNC_POL;
      vsync_q  <= in_win(v_d, VS_LO, VS_LEN) ? SYNC_POL : ~SYNC_POL;
      // Gating with adv keeps the strobes to the wrap event only; reset never fires them.
      frame_q  <= adv && (h_d == '0) && (v_d == '0);
      vblank_q <= adv && (h_d == '0) && (v_d == V_ACT);
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign h_visable   = hvis_q;
  assign v_visable   = vvis_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_tick  = frame_q;
  assign vblank_tick = vblank_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a time-based raster model predicts every cycle of two
// differently parameterised instances; random mid-frame resets restart both.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default horizontal timing, short vertical frame, CLK_DIV=4.
  localparam int A_DIV = 4, A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 4, A_VF = 1, A_VS = 1, A_VB = 1;
  // Instance B: small raster, CLK_DIV=1, active-high syncs.
  localparam int B_DIV = 1, B_HA = 16, B_HF = 2, B_HS = 3, B_HB = 3;
  localparam int B_VA = 10, B_VF = 2, B_VS = 2, B_VB = 3;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic hv, vv, hs, vs, pt, ft, vt;
  } obs_t;

  logic [9:0] a_h, a_v, b_h, b_v;
  logic a_hv, a_vv, a_hs, a_vs, a_pt, a_ft, a_vt;
  logic b_hv, b_vv, b_hs, b_vs, b_pt, b_ft, b_vt;

  vga_sync_gen #(.CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
                 .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .SYNC_POL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .hcount(a_h), .vcount(a_v), .h_visable(a_hv), .v_visable(a_vv),
    .hsync(a_hs), .vsync(a_vs), .pix_tick(a_pt), .frame_tick(a_ft), .vblank_tick(a_vt));

  vga_sync_gen #(.CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
                 .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .SYNC_POL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .hcount(b_h), .vcount(b_v), .h_visable(b_hv), .v_visable(b_vv),
    .hsync(b_hs), .vsync(b_vs), .pix_tick(b_pt), .frame_tick(b_ft), .vblank_tick(b_vt));

  int checks = 0;
  int errors = 0;
  obs_t qa[$];
  obs_t qb[$];

  // Expected outputs t clocks after the last reset edge: t/div pixels have elapsed.
  function automatic obs_t model(input int t, input int div, input int ha, input int hf,
                                 input int hs, input int hb, input int va, input int vf,
                                 input int vs, input int vb, input bit pol);
    obs_t o;
    int ht, vtot, p, h, v;
    bit pt;
    ht   = ha + hf + hs + hb;
    vtot = va + vf + vs + vb;
    p    = t / div;
    h    = p % ht;
    v    = (p / ht) % vtot;
    pt   = (t > 0) && (t % div == 0);
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hv = (h < ha);
    o.vv = (v < va);
    o.hs = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
    o.vs = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
    o.pt = pt;
    o.ft = pt && h == 0 && v == 0;
    o.vt = pt && h == 0 && v == va;
    return o;
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_obs(input string name, input int t, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got h=%0d v=%0d hv=%b vv=%b hs=%b vs=%b pt=%b ft=%b vt=%b exp h=%0d v=%0d hv=%b vv=%b hs=%b vs=%b pt=%b ft=%b vt=%b",
               name, t, got.h, got.v, got.hv, got.vv, got.hs, got.vs, got.pt, got.ft, got.vt,
               exp.h, exp.v, exp.hv, exp.vv, exp.hs, exp.vs, exp.pt, exp.ft, exp.vt);
    end
  endtask

  // Stimulus side of the scoreboard: track time since reset, push predictions.
  int tq[$];
  initial begin
    int t;
    bit go;
    t  = 0;
    go = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        t  = 0;
        go = 1'b1;
      end else if (go) begin
        t++;
      end
      if (go) begin
        qa.push_back(model(t, A_DIV, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0));
        qb.push_back(model(t, B_DIV, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1));
        tq.push_back(t);
      end
    end
  end

  // Monitor: every settled cycle is an output sample.
  initial begin
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        int t;
        obs_t ea, eb;
        t  = tq.pop_front();
        ea = qa.pop_front();
        eb = qb.pop_front();
        check_obs("raster_a", t, {a_h, a_v, a_hv, a_vv, a_hs, a_vs, a_pt, a_ft, a_vt}, ea);
        check_obs("raster_b", t, {b_h, b_v, b_hv, b_vv, b_hs, b_vs, b_pt, b_ft, b_vt}, eb);
      end
    end
  end

  initial begin
    int n_ft_a, n_vt_a, n_hs_a, n_vs_a, n_ft_b, n_vt_b, exp_ft_b, exp_vt_b, both, first_pt;
    int run, b_frame;
    n_ft_a = 0; n_vt_a = 0; n_hs_a = 0; n_vs_a = 0;
    n_ft_b = 0; n_vt_b = 0; both = 0; first_pt = -1;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Two full frames of A (5600 pixels x 4 clocks each).
    run = 2 * 5600 * A_DIV;
    for (int c = 1; c <= run; c++) begin
      @(negedge clk);
      if (a_pt && first_pt < 0) first_pt = c;
      if (a_ft) n_ft_a++;
      if (a_vt) n_vt_a++;
      if (a_pt && !a_hs) n_hs_a++;
      if (a_pt && !a_vs) n_vs_a++;
      if (b_ft) n_ft_b++;
      if (b_vt) n_vt_b++;
      if ((a_ft && a_vt) || (b_ft && b_vt)) both++;
    end

    b_frame = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);
    exp_ft_b = 0;
    exp_vt_b = 0;
    for (int p = 1; p <= run; p++) begin
      if (p % b_frame == 0) exp_ft_b++;
      if (p % b_frame == B_VA * (B_HA + B_HF + B_HS + B_HB)) exp_vt_b++;
    end

    check_int("first_pix_tick_clk", first_pt, A_DIV);
    check_int("frame_ticks_a", n_ft_a, 2);
    check_int("vblank_ticks_a", n_vt_a, 2);
    check_int("hsync_low_pixels_a", n_hs_a, 2 * A_HS * (A_VA + A_VF + A_VS + A_VB));
    check_int("vsync_low_pixels_a", n_vs_a, 2 * A_VS * (A_HA + A_HF + A_HS + A_HB));
    check_int("frame_ticks_b", n_ft_b, exp_ft_b);
    check_int("vblank_ticks_b", n_vt_b, exp_vt_b);
    check_int("frame_and_vblank_same_clk", both, 0);

    // Random mid-frame resets; divider must restart so A's next tick is CLK_DIV clocks later.
    for (int k = 0; k < 4; k++) begin
      int n;
      repeat ($urandom_range(300, 4000)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check_int("reset_no_frame_tick", int'(a_ft | b_ft), 0);
      check_int("reset_hcount_zero", int'(a_h), 0);
      rst = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!a_pt && n < 16);
      check_int("pix_tick_after_reset", n, A_DIV);
    end

    repeat (2000) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
